ysyx_210238_trap_ctrl: RTL and testbench

Trap sequencer that owns the CSR file's clint write port (i_clint_csr_wen/waddr/wdata). On a commit-point request it takes a timer interrupt, an ecall or an mret, and writes mepc, mcause and mstatus one per cycle through the single write port. It then issues a one-cycle PC redirect to the fetch stage. The core pipeline is stalled while the block is busy, so CPU-port CSR writes, which take priority in the CSR file, never collide with its writes.

---
 rtl/ysyx_210238_trap_ctrl_if.sv | 25 ++
 rtl/ysyx_210238_trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ysyx_210238_trap_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_210238_trap_ctrl_if.sv
// Clint-side CSR write port and fetch redirect bundle
// driven by the trap sequencer.
interface ysyx_210238_trap_ctrl_if;
  logic        o_csr_wen;
  logic [11:0] o_csr_waddr;
  logic [63:0] o_csr_wdata;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;

  modport master (
    output o_csr_wen,
    output o_csr_waddr,
    output o_csr_wdata,
    output o_redirect_valid,
    output o_redirect_pc
  );

  modport slave (
    input o_csr_wen,
    input o_csr_waddr,
    input o_csr_wdata,
    input o_redirect_valid,
    input o_redirect_pc
  );
endinterface

// File: rtl/ysyx_210238_trap_ctrl.sv
// Trap sequencer: timer interrupt / ecall / mret entry and exit,
// one CSR write per cycle through the clint port, then a PC redirect.
module ysyx_210238_trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic [63:0] i_pc,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic [63:0] i_csr_mstatus,
  input  logic [63:0] i_csr_mepc,
  input  logic [63:0] i_csr_mtvec,
  input  logic        i_global_int_en,
  input  logic        i_mtime_int_en,
  input  logic        i_mtime_int_pend,
  output logic        o_accept,
  output logic        o_stall,
  ysyx_210238_trap_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    REDIRECT
  } state_t;

  localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  state_t      r_state;
  state_t      w_nxt;
  logic [63:0] r_pc;
  logic [63:0] r_cause;
  logic        r_mret;
  logic [63:0] r_snap;
  logic        r_wen;
  logic [11:0] r_waddr;
  logic [63:0] r_wdata;
  logic        r_rv;
  logic [63:0] r_rpc;

  logic        w_idle;
  logic        w_int;
  logic        w_accept;
  logic        w_is_mret;
  logic [63:0] w_pc_src;
  logic [63:0] w_snap;
  logic        w_mret_src;
  logic [63:0] w_mstatus;
  logic [63:0] w_tgt;

  assign w_idle    = (r_state == IDLE);
  assign w_int     = i_global_int_en & i_mtime_int_en
                   & i_mtime_int_pend;
  assign w_accept  = w_idle & i_instr_valid
                   & (w_int | i_ecall | i_mret);
  assign w_is_mret = ~w_int & ~i_ecall & i_mret;

  assign o_accept = w_accept;
  assign o_stall  = w_accept | ~w_idle;

  // Mret enters W_MSTATUS straight from IDLE, before the latches fill.
  assign w_pc_src   = w_idle ? i_pc : r_pc;
  assign w_snap     = w_idle ? i_csr_mstatus : r_snap;
  assign w_mret_src = w_idle ? w_is_mret : r_mret;

  always_comb begin
    w_mstatus = w_snap;
    w_mstatus[12:11] = 2'b11;
    if (w_mret_src) begin
      w_mstatus[3] = w_snap[7];
      w_mstatus[7] = 1'b1;
    end else begin
      w_mstatus[7] = w_snap[3];
      w_mstatus[3] = 1'b0;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_nxt = w_is_mret ? W_MSTATUS : W_MEPC;
      end
      W_MEPC:    w_nxt = W_MCAUSE;
      W_MCAUSE:  w_nxt = W_MSTATUS;
      W_MSTATUS: w_nxt = REDIRECT;
      REDIRECT:  w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
  end

  assign w_tgt = r_mret ? i_csr_mepc
                        : (i_csr_mtvec & ~64'h3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_mret  <= 1'b0;
      r_snap  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_pc    <= i_pc;
        r_cause <= w_int ? CAUSE_TIMER : CAUSE_ECALL;
        r_mret  <= w_is_mret;
        r_snap  <= i_csr_mstatus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rv    <= 1'b0;
      r_rpc   <= '0;
    end else begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rv    <= (w_nxt == REDIRECT);
      unique case (1'b1)
        (w_nxt == W_MEPC): begin
          r_wen   <= 1'b1;
          r_waddr <= ADDR_MEPC;
          r_wdata <= w_pc_src;
        end
        (w_nxt == W_MCAUSE): begin
          r_wen   <= 1'b1;
          r_waddr <= ADDR_MCAUSE;
          r_wdata <= r_cause;
        end
        (w_nxt == W_MSTATUS): begin
          r_wen   <= 1'b1;
          r_waddr <= ADDR_MSTATUS;
          r_wdata <= w_mstatus;
        end
        default: ;
      endcase
      if (r_state == REDIRECT)
        r_rpc <= w_tgt;
    end
  end

  assign bus.o_csr_wen        = r_wen;
  assign bus.o_csr_waddr      = r_waddr;
  assign bus.o_csr_wdata      = r_wdata;
  assign bus.o_redirect_valid = r_rv;
  // Target is sampled live during REDIRECT, then held.
  assign bus.o_redirect_pc    = r_rv ? w_tgt : r_rpc;

endmodule

// File: tb/tb_ysyx_210238_trap_ctrl.sv
// Bench for the trap sequencer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_ysyx_210238_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_instr_valid;
  logic [63:0] i_pc;
  logic        i_ecall;
  logic        i_mret;
  logic [63:0] i_csr_mstatus;
  logic [63:0] i_csr_mepc;
  logic [63:0] i_csr_mtvec;
  logic        i_global_int_en;
  logic        i_mtime_int_en;
  logic        i_mtime_int_pend;
  logic        o_accept;
  logic        o_stall;

  ysyx_210238_trap_ctrl_if bus();

  ysyx_210238_trap_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_instr_valid    (i_instr_valid),
    .i_pc             (i_pc),
    .i_ecall          (i_ecall),
    .i_mret           (i_mret),
    .i_csr_mstatus    (i_csr_mstatus),
    .i_csr_mepc       (i_csr_mepc),
    .i_csr_mtvec      (i_csr_mtvec),
    .i_global_int_en  (i_global_int_en),
    .i_mtime_int_en   (i_mtime_int_en),
    .i_mtime_int_pend (i_mtime_int_pend),
    .o_accept         (o_accept),
    .o_stall          (o_stall),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each accepted request expands into a list of per-cycle
  // expected events; an empty list means the block is idle.
  typedef struct {
    logic        wen;
    logic [11:0] a;
    logic [63:0] d;
    logic        rv;
    logic        mret;
  } ev_t;

  ev_t         q[$];
  ev_t         m_cur;
  logic        m_busy;
  logic        m_int;
  logic        m_acc;
  logic [63:0] m_rpc = '0;
  logic [63:0] m_s;
  logic [63:0] m_ms;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_rpc = '0;
    end else begin
      m_busy = (q.size() != 0);
      if (m_busy) m_cur = q.pop_front();
      else m_cur = '{1'b0, 12'h0, 64'h0, 1'b0, 1'b0};
      m_int = i_global_int_en & i_mtime_int_en & i_mtime_int_pend;
      m_acc = !m_busy && i_instr_valid
              && (m_int || i_ecall || i_mret);
      if (m_cur.rv)
        m_rpc = m_cur.mret ? i_csr_mepc
                           : (i_csr_mtvec / 4) * 4;
      chk("m_accept", o_accept, m_acc);
      chk("m_stall", o_stall, m_acc | m_busy);
      chk("m_wen", bus.o_csr_wen, m_cur.wen);
      chk("m_waddr", bus.o_csr_waddr, m_cur.a);
      chk("m_wdata", bus.o_csr_wdata, m_cur.d);
      chk("m_rv", bus.o_redirect_valid, m_cur.rv);
      chk("m_rpc", bus.o_redirect_pc, m_rpc);
      if (m_acc) begin
        m_s = i_csr_mstatus;
        if (!m_int && !i_ecall) begin
          m_ms = (m_s & ~64'h1888) | 64'h1880
               | (m_s[7] ? 64'h8 : 64'h0);
          q.push_back('{1'b1, 12'h300, m_ms, 1'b0, 1'b0});
          q.push_back('{1'b0, 12'h0, 64'h0, 1'b1, 1'b1});
        end else begin
          m_ms = (m_s & ~64'h1888) | 64'h1800
               | (m_s[3] ? 64'h80 : 64'h0);
          q.push_back('{1'b1, 12'h341, i_pc, 1'b0, 1'b0});
          q.push_back('{1'b1, 12'h342,
                        m_int ? 64'h8000_0000_0000_0007 : 64'd11,
                        1'b0, 1'b0});
          q.push_back('{1'b1, 12'h300, m_ms, 1'b0, 1'b0});
          q.push_back('{1'b0, 12'h0, 64'h0, 1'b1, 1'b0});
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_instr_valid    = 1'b0;
    i_ecall          = 1'b0;
    i_mret           = 1'b0;
    i_global_int_en  = 1'b0;
    i_mtime_int_en   = 1'b0;
    i_mtime_int_pend = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    quiet();
    i_pc          = '0;
    i_csr_mstatus = '0;
    i_csr_mepc    = '0;
    i_csr_mtvec   = '0;
    #3;
    chk("rst_wen", bus.o_csr_wen, 0);
    chk("rst_waddr", bus.o_csr_waddr, 0);
    chk("rst_wdata", bus.o_csr_wdata, 0);
    chk("rst_rv", bus.o_redirect_valid, 0);
    chk("rst_rpc", bus.o_redirect_pc, 0);
    chk("rst_stall", o_stall, 0);
    #9 rst_n = 1'b1;
    nxt();

    // ecall
    i_instr_valid = 1; i_ecall = 1;
    i_pc = 64'h8000_0010;
    i_csr_mstatus = 64'h1888;
    i_csr_mtvec = 64'h8000_0103;
    @(negedge clk);
    chk("ec_c0_accept", o_accept, 1);
    chk("ec_c0_stall", o_stall, 1);
    chk("ec_c0_wen", bus.o_csr_wen, 0);
    nxt(); quiet();
    @(negedge clk);
    chk("ec_c1_wen", bus.o_csr_wen, 1);
    chk("ec_c1_addr", bus.o_csr_waddr, 12'h341);
    chk("ec_c1_data", bus.o_csr_wdata, 64'h8000_0010);
    chk("ec_c1_stall", o_stall, 1);
    nxt(); @(negedge clk);
    chk("ec_c2_addr", bus.o_csr_waddr, 12'h342);
    chk("ec_c2_data", bus.o_csr_wdata, 64'd11);
    nxt(); @(negedge clk);
    chk("ec_c3_addr", bus.o_csr_waddr, 12'h300);
    chk("ec_c3_data", bus.o_csr_wdata, 64'h1880);
    nxt(); @(negedge clk);
    chk("ec_c4_rv", bus.o_redirect_valid, 1);
    chk("ec_c4_rpc", bus.o_redirect_pc, 64'h8000_0100);
    chk("ec_c4_wen", bus.o_csr_wen, 0);
    chk("ec_c4_stall", o_stall, 1);
    nxt(); @(negedge clk);
    chk("ec_c5_rv", bus.o_redirect_valid, 0);
    chk("ec_c5_rpc_hold", bus.o_redirect_pc, 64'h8000_0100);
    chk("ec_c5_stall", o_stall, 0);
    nxt();

    // back-to-back ecalls
    i_instr_valid = 1; i_ecall = 1; i_pc = 64'h8000_0030;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_accept", o_accept, (i == 0 || i == 5) ? 1 : 0);
      nxt();
      if (i == 0) i_pc = 64'h8000_0040;
      if (i == 5) quiet();
    end
    @(negedge clk);
    chk("b2b_mepc", bus.o_csr_wdata, 64'h8000_0040);
    repeat (4) nxt();

    // interrupt beats ecall
    i_instr_valid = 1; i_ecall = 1; i_pc = 64'h8000_0020;
    i_global_int_en = 1; i_mtime_int_en = 1; i_mtime_int_pend = 1;
    @(negedge clk);
    chk("int_accept", o_accept, 1);
    nxt(); quiet();
    @(negedge clk);
    chk("int_mepc", bus.o_csr_wdata, 64'h8000_0020);
    nxt(); @(negedge clk);
    chk("int_mcause", bus.o_csr_wdata, 64'h8000_0000_0000_0007);
    repeat (3) nxt();

    // pending interrupt, global enable off
    i_instr_valid = 1; i_mtime_int_en = 1; i_mtime_int_pend = 1;
    repeat (3) begin
      @(negedge clk);
      chk("noint_accept", o_accept, 0);
      chk("noint_stall", o_stall, 0);
      chk("noint_wen", bus.o_csr_wen, 0);
      nxt();
    end
    quiet();

    // mret
    i_instr_valid = 1; i_mret = 1;
    i_csr_mstatus = 64'h1880; i_csr_mepc = 64'h8000_0024;
    @(negedge clk);
    chk("mret_accept", o_accept, 1);
    nxt(); quiet();
    @(negedge clk);
    chk("mret_c1_addr", bus.o_csr_waddr, 12'h300);
    chk("mret_c1_data", bus.o_csr_wdata, 64'h1888);
    nxt(); @(negedge clk);
    chk("mret_c2_rv", bus.o_redirect_valid, 1);
    chk("mret_c2_rpc", bus.o_redirect_pc, 64'h8000_0024);
    chk("mret_c2_wen", bus.o_csr_wen, 0);
    nxt();

    // async reset during W_MCAUSE
    i_instr_valid = 1; i_ecall = 1; i_pc = 64'h8000_0050;
    @(negedge clk);
    nxt(); quiet();
    nxt();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", bus.o_csr_wen, 0);
    chk("arst_waddr", bus.o_csr_waddr, 0);
    chk("arst_wdata", bus.o_csr_wdata, 0);
    chk("arst_rv", bus.o_redirect_valid, 0);
    chk("arst_stall", o_stall, 0);
    #12 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_after_wen", bus.o_csr_wen, 0);
      chk("arst_after_rv", bus.o_redirect_valid, 0);
      chk("arst_after_stall", o_stall, 0);
    end
    nxt();

    // randomized traffic, checked by the model
    repeat (3000) begin
      i_instr_valid    = ($urandom_range(0, 1) == 1);
      i_ecall          = ($urandom_range(0, 4) == 0);
      i_mret           = ($urandom_range(0, 4) == 0);
      i_global_int_en  = ($urandom_range(0, 1) == 1);
      i_mtime_int_en   = ($urandom_range(0, 1) == 1);
      i_mtime_int_pend = ($urandom_range(0, 3) == 0);
      i_pc             = {$urandom, $urandom};
      i_csr_mstatus    = {$urandom, $urandom};
      i_csr_mepc       = {$urandom, $urandom};
      i_csr_mtvec      = {$urandom, $urandom};
      nxt();
    end
    quiet();
    repeat (6) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
